// File: rtl/ct_ifu_icache_data_array_banked.sv
// Banked icache data array: BANK_NUM single-port banks behind one index, read port beats refill port.
// Read latency 1+OUT_REG cycles; one-entry write buffer parks a refill that collides with a read.
// Backpressure: wr_rdy drops while the buffer holds a parked write; reads are never stalled.
//
// Ports: forever_cpuclk/cpurst (sync active-high), rd_* fetch read port, wr_* refill write port.
// Enable bit b selects bank b; bank b's data sits at [(BANK_NUM-b)*BANK_WIDTH-1 -: BANK_WIDTH]
// of rd_dout/wr_din, so bank 0 is the MSB slice.
module ct_ifu_icache_data_array_banked #(
    parameter int BANK_NUM    = 4,
    parameter int BANK_WIDTH  = 32,
    parameter int INDEX_WIDTH = 10,
    parameter int OUT_REG     = 0
) (
    input  logic                           forever_cpuclk,
    input  logic                           cpurst,
    input  logic                           rd_vld,
    input  logic [INDEX_WIDTH-1:0]         rd_index,
    input  logic [BANK_NUM-1:0]            rd_bank_en,
    output logic [BANK_NUM*BANK_WIDTH-1:0] rd_dout,
    output logic                           rd_dout_vld,
    input  logic                           wr_vld,
    output logic                           wr_rdy,
    input  logic [INDEX_WIDTH-1:0]         wr_index,
    input  logic [BANK_NUM-1:0]            wr_bank_en,
    input  logic [BANK_NUM*BANK_WIDTH-1:0] wr_din
);
    localparam int DW    = BANK_NUM * BANK_WIDTH;
    localparam int DEPTH = 1 << INDEX_WIDTH;

    logic                   buf_vld;
    logic [INDEX_WIDTH-1:0] buf_index;
    logic [BANK_NUM-1:0]    buf_bank_en;
    logic [DW-1:0]          buf_din;

    logic                   wr_acc;
    logic                   cand_vld;
    logic [INDEX_WIDTH-1:0] cand_index;
    logic [BANK_NUM-1:0]    cand_bank_en;
    logic [DW-1:0]          cand_din;
    logic                   conflict;
    logic                   do_write;
    logic                   fwd_hit;

    logic                   s1_vld;
    logic [DW-1:0]          s1_dat;

    assign wr_rdy = !buf_vld;
    assign wr_acc = wr_vld && wr_rdy;

    // A parked write is the only candidate; new writes are held off by wr_rdy=0.
    assign cand_vld     = buf_vld || wr_acc;
    assign cand_index   = buf_vld ? buf_index   : wr_index;
    assign cand_bank_en = buf_vld ? buf_bank_en : wr_bank_en;
    assign cand_din     = buf_vld ? buf_din     : wr_din;

    // Any shared bank blocks the whole write so the write lands atomically.
    assign conflict = rd_vld && |(rd_bank_en & cand_bank_en);
    assign do_write = cand_vld && !conflict && !cpurst;

    assign fwd_hit  = buf_vld && (rd_index == buf_index);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            buf_vld     <= 1'b0;
            buf_index   <= '0;
            buf_bank_en <= '0;
            buf_din     <= '0;
        end else if (wr_acc && conflict) begin
            buf_vld     <= 1'b1;
            buf_index   <= wr_index;
            buf_bank_en <= wr_bank_en;
            buf_din     <= wr_din;
        end else if (buf_vld && !conflict) begin
            buf_vld     <= 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= rd_vld;
        end
    end

    for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
        localparam int HI = (BANK_NUM - b) * BANK_WIDTH - 1;

        logic [BANK_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge forever_cpuclk) begin
            if (do_write && cand_bank_en[b]) begin
                mem[cand_index] <= cand_din[HI -: BANK_WIDTH];
            end
        end

        // Registered read; the slice only moves on an issued read so it holds between reads.
        // A parked write at the same index shadows the array for its enabled banks.
        always_ff @(posedge forever_cpuclk) begin
            if (cpurst) begin
                s1_dat[HI -: BANK_WIDTH] <= '0;
            end else if (rd_vld) begin
                if (!rd_bank_en[b]) begin
                    s1_dat[HI -: BANK_WIDTH] <= '0;
                end else if (fwd_hit && buf_bank_en[b]) begin
                    s1_dat[HI -: BANK_WIDTH] <= buf_din[HI -: BANK_WIDTH];
                end else begin
                    s1_dat[HI -: BANK_WIDTH] <= mem[rd_index];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic          s2_vld;
        logic [DW-1:0] s2_dat;

        always_ff @(posedge forever_cpuclk) begin
            if (cpurst) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_dat <= s1_dat;
                end
            end
        end

        assign rd_dout_vld = s2_vld;
        assign rd_dout     = s2_dat;
    end else begin : g_no_out_reg
        assign rd_dout_vld = s1_vld;
        assign rd_dout     = s1_dat;
    end
endmodule
